// File: rtl/seq_launcher.sv
// seq_launcher: host-side driver for the control-word sequencer.
// Issues a start pulse, paced continue strobes, and watches for ack/end.
module seq_launcher #(
    parameter int STEP_W  = 8,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              abort,
    input  logic              step_en,
    input  logic              seq_ready,
    output logic              seq_start,
    output logic              seq_continue,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [STEP_W-1:0] steps_issued
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ACK,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_EARLY = 2'b01;
    localparam logic [1:0] ST_TMO   = 2'b10;
    localparam logic [1:0] ST_ABORT = 2'b11;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_cmd_ready;
    logic              r_start;
    logic              r_cont;
    logic              r_busy;
    logic              r_done;
    logic [1:0]        r_status;
    logic [STEP_W-1:0] r_issued;
    logic [STEP_W-1:0] r_left;
    logic [TO_W-1:0]   r_to_cnt;

    logic              w_accept;
    logic              w_abort;
    logic              w_timeout;
    logic              w_cont_nxt;
    logic [1:0]        w_status_nxt;
    logic [STEP_W-1:0] w_issued_nxt;
    logic [STEP_W-1:0] w_left_nxt;
    logic [TO_W-1:0]   w_to_nxt;

    // abort is meaningless once idle or already finishing the run
    assign w_accept  = (r_state == S_IDLE) && cmd_valid;
    assign w_abort   = abort && (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_timeout = (r_to_cnt == TO_LAST);

    assign cmd_ready    = r_cmd_ready;
    assign seq_start    = r_start;
    assign seq_continue = r_cont;
    assign busy         = r_busy;
    assign done         = r_done;
    assign status       = r_status;
    assign steps_issued = r_issued;

    // state, counters and all outputs are registered here
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_start     <= 1'b0;
            r_cont      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_status    <= ST_OK;
            r_issued    <= '0;
            r_left      <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == S_IDLE);
            r_start     <= (w_next == S_START);
            r_cont      <= w_cont_nxt;
            r_busy      <= (w_next != S_IDLE);
            r_done      <= (w_next == S_DONE);
            r_status    <= w_status_nxt;
            r_issued    <= w_issued_nxt;
            r_left      <= w_left_nxt;
            r_to_cnt    <= w_to_nxt;
        end
    end

    // next-state: abort overrides every other transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) w_next = S_START;
            end
            S_START: w_next = S_ACK;
            S_ACK: begin
                if (!seq_ready) begin
                    w_next = (r_left != '0) ? S_RUN : S_DRAIN;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_RUN: begin
                if (seq_ready) begin
                    w_next = S_DONE;
                end else if (step_en && (r_left == STEP_W'(1))) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (seq_ready || w_timeout) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_DONE;
    end

    // next values of the continue strobe, counters and run status
    always_comb begin
        w_status_nxt = r_status;
        w_issued_nxt = r_issued;
        w_left_nxt   = r_left;
        w_to_nxt     = r_to_cnt;
        w_cont_nxt   = (r_state == S_RUN) && step_en
                       && !seq_ready && !w_abort;
        if (w_accept) begin
            w_left_nxt   = cmd_steps;
            w_issued_nxt = '0;
            w_status_nxt = ST_OK;
        end
        if (w_cont_nxt) begin
            w_left_nxt = r_left - 1'b1;
            if (r_issued != '1) w_issued_nxt = r_issued + 1'b1;
        end
        if (w_next != r_state) begin
            w_to_nxt = '0;
        end else if ((r_state == S_ACK || r_state == S_DRAIN)
                     && (r_to_cnt != '1)) begin
            w_to_nxt = r_to_cnt + 1'b1;
        end
        case (r_state)
            S_ACK: begin
                if (seq_ready && w_timeout) w_status_nxt = ST_TMO;
            end
            S_RUN: begin
                if (seq_ready) w_status_nxt = ST_EARLY;
            end
            S_DRAIN: begin
                if (!seq_ready && w_timeout) w_status_nxt = ST_TMO;
            end
            default: ;
        endcase
        if (w_abort) w_status_nxt = ST_ABORT;
    end

endmodule

// File: tb/tb_seq_launcher.sv
// tb_seq_launcher: directed runs of seq_launcher with
// hand-computed pulse counts, status and step totals.
module tb_seq_launcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_steps;
    logic       abort;
    logic       step_en;
    logic       seq_ready;
    logic       seq_start;
    logic       seq_continue;
    logic       busy;
    logic       done;
    logic [1:0] status;
    logic [7:0] steps_issued;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int n_start, n_cont, n_done;
    int first_c, last_c, s_cyc, d_cyc;
    logic [1:0] d_status;
    logic [7:0] d_issued;
    bit got;

    always #5 clk = ~clk;

    seq_launcher #(.STEP_W(8), .TO_W(8), .TIMEOUT(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_steps    (cmd_steps),
        .abort        (abort),
        .step_en      (step_en),
        .seq_ready    (seq_ready),
        .seq_start    (seq_start),
        .seq_continue (seq_continue),
        .busy         (busy),
        .done         (done),
        .status       (status),
        .steps_issued (steps_issued)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic clr();
        n_start = 0; n_cont = 0; n_done = 0;
        first_c = -1; last_c = -1; s_cyc = -1; d_cyc = -1;
        d_status = 2'b00; d_issued = 8'd0;
    endtask

    // advance one cycle and sample outputs 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (seq_start) begin
            n_start++;
            s_cyc = cyc;
        end
        if (seq_continue) begin
            n_cont++;
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
        end
        if (done) begin
            n_done++;
            d_status = status;
            d_issued = steps_issued;
            d_cyc = cyc;
        end
    endtask

    task automatic wait_done(input int budget);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (done) got = 1'b1;
        end
        if (!got) chk("wait_done", 0, 1);
    endtask

    task automatic wait_start(input int budget);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (seq_start) got = 1'b1;
        end
        if (!got) chk("wait_start", 0, 1);
    endtask

    task automatic wait_cont(input int n, input int budget);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (n_cont >= n) got = 1'b1;
        end
        if (!got) chk("wait_cont", 0, 1);
    endtask

    task automatic launch(input logic [7:0] steps);
        cmd_steps = steps;
        cmd_valid = 1'b1;
        wait_start(5);
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_steps = 8'd0;
        abort = 1'b0; step_en = 1'b0; seq_ready = 1'b1;
        clr();
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_start", seq_start, 0);
        chk("rst_cont", seq_continue, 0);
        chk("rst_status", status, 0);
        chk("rst_issued", steps_issued, 0);
        reset = 1'b0;
        tick();

        // abort while idle has no effect
        abort = 1'b1;
        tick(); tick();
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_done", done, 0);
        abort = 1'b0;

        // 3 steps, step_en held high, normal completion
        clr();
        step_en = 1'b1;
        launch(8'd3);
        chk("t1_busy", busy, 1);
        chk("t1_cmd_ready", cmd_ready, 0);
        tick(); tick();
        seq_ready = 1'b0;
        wait_cont(3, 20);
        tick();
        seq_ready = 1'b1;
        wait_done(20);
        chk("t1_starts", n_start, 1);
        chk("t1_conts", n_cont, 3);
        chk("t1_status", d_status, 0);
        chk("t1_issued", d_issued, 3);
        chk("t1_cont_run", last_c - first_c, 2);
        tick();
        chk("t1_ready_back", cmd_ready, 1);
        chk("t1_done_pulse", done, 0);

        // 4 steps with step_en alternating every cycle
        clr();
        step_en = 1'b1;
        launch(8'd4);
        seq_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step_en = ~step_en;
            tick();
            if (n_cont >= 4) got = 1'b1;
        end
        if (!got) chk("t2_wait", 0, 1);
        step_en = 1'b1;
        tick();
        seq_ready = 1'b1;
        wait_done(20);
        chk("t2_conts", n_cont, 4);
        chk("t2_spread", last_c - first_c + 1, 7);
        chk("t2_status", d_status, 0);
        chk("t2_issued", d_issued, 4);

        // 10 steps, sequencer finishes after 5 continues
        tick();
        clr();
        step_en = 1'b1;
        launch(8'd10);
        seq_ready = 1'b0;
        wait_cont(5, 30);
        seq_ready = 1'b1;
        wait_done(10);
        tick(); tick(); tick();
        chk("t3_conts", n_cont, 5);
        chk("t3_status", d_status, 1);
        chk("t3_issued", d_issued, 5);
        chk("t3_dones", n_done, 1);

        // sequencer never acknowledges the start
        clr();
        launch(8'd2);
        wait_done(200);
        chk("t4_latency", d_cyc - s_cyc, 65);
        chk("t4_status", d_status, 2);
        chk("t4_issued", d_issued, 0);
        chk("t4_conts", n_cont, 0);

        // abort after two continues
        tick();
        clr();
        step_en = 1'b1;
        launch(8'd5);
        seq_ready = 1'b0;
        wait_cont(2, 20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_cont_low", seq_continue, 0);
        chk("t5_done", done, 1);
        chk("t5_status", status, 3);
        chk("t5_issued", steps_issued, 2);
        seq_ready = 1'b1;
        tick(); tick();
        chk("t5_conts", n_cont, 2);
        chk("t5_dones", n_done, 1);

        // reset in the middle of a run
        clr();
        launch(8'd5);
        seq_ready = 1'b0;
        wait_cont(1, 20);
        reset = 1'b1;
        tick();
        chk("t6_cont", seq_continue, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cmd_ready", cmd_ready, 1);
        chk("t6_issued", steps_issued, 0);
        chk("t6_status", status, 0);
        reset = 1'b0;
        seq_ready = 1'b1;
        tick(); tick(); tick();
        chk("t6_no_done", n_done, 0);

        // zero steps, cmd_valid held through the whole run
        clr();
        step_en = 1'b1;
        cmd_steps = 8'd0;
        cmd_valid = 1'b1;
        wait_start(5);
        seq_ready = 1'b0;
        tick(); tick(); tick();
        seq_ready = 1'b1;
        wait_done(20);
        chk("t7_starts", n_start, 1);
        chk("t7_conts", n_cont, 0);
        chk("t7_status", d_status, 0);
        chk("t7_issued", d_issued, 0);
        chk("t7_ready_at_done", cmd_ready, 0);
        tick();
        chk("t7_ready_back", cmd_ready, 1);
        chk("t7_no_start_yet", seq_start, 0);
        tick();
        chk("t7_second_start", seq_start, 1);
        chk("t7_starts2", n_start, 2);
        cmd_valid = 1'b0;
        seq_ready = 1'b0;
        tick(); tick(); tick();
        seq_ready = 1'b1;
        wait_done(20);
        chk("t7_dones", n_done, 2);
        chk("t7_conts2", n_cont, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
